fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the MIPS core.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents the fetched instruction and PC+4 to the decode/control stage.
- Honours stalls from the hazard unit and redirects (taken branch / jump) from decode; squashed slots become all-zero NOP bubbles.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: state encoding and core constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PKG_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] PKG_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with load/hold/flush controls; a flush writes a NOP bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = PKG_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Flush outranks load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else begin
      r_instr    <= r_instr;
      r_pc_plus4 <= r_pc_plus4;
      r_valid    <= r_valid;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding imem request, stall hold buffer,
// and redirect handling that discards in-flight words.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PKG_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PKG_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] pc_out
);

  fetch_state_e r_state, w_state_n;
  logic [31:0]  r_pc, w_pc_n;
  logic [31:0]  r_req_addr, w_req_addr_n;
  logic [31:0]  r_hold_instr, r_hold_pc4;
  logic         w_hold_capture;
  logic         w_load, w_flush;
  logic [31:0]  w_load_instr, w_load_pc4;
  logic [31:0]  w_pc_plus4, w_target;

  assign w_pc_plus4 = r_pc + WORD_BYTES;
  assign w_target   = word_align(redirect_target);

  // Next-state, PC and IF/ID control; redirect always wins over stall and data.
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_req_addr_n   = r_req_addr;
    w_hold_capture = 1'b0;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    w_load_instr   = imem_rdata;
    w_load_pc4     = w_pc_plus4;
    case (r_state)
      ST_FETCH: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          w_pc_n  = w_target;
          if (imem_ready) begin
            w_req_addr_n = w_target;
          end else begin
            w_state_n = ST_DISCARD;
          end
        end else if (imem_ready) begin
          if (stall) begin
            w_hold_capture = 1'b1;
            w_state_n      = ST_HOLD;
          end else begin
            w_load       = 1'b1;
            w_pc_n       = w_pc_plus4;
            w_req_addr_n = w_pc_plus4;
          end
        end else begin
          w_flush = !stall;
        end
      end
      ST_HOLD: begin
        w_load_instr = r_hold_instr;
        w_load_pc4   = r_hold_pc4;
        if (redirect_valid) begin
          w_flush      = 1'b1;
          w_pc_n       = w_target;
          w_req_addr_n = w_target;
          w_state_n    = ST_FETCH;
        end else if (!stall) begin
          w_load       = 1'b1;
          w_pc_n       = w_pc_plus4;
          w_req_addr_n = w_pc_plus4;
          w_state_n    = ST_FETCH;
        end else begin
          w_state_n = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        w_flush = redirect_valid || !stall;
        w_pc_n  = redirect_valid ? w_target : r_pc;
        if (imem_ready) begin
          // Stale word dropped; refetch from the most recent redirect target.
          w_req_addr_n = w_pc_n;
          w_state_n    = ST_FETCH;
        end else begin
          w_state_n = ST_DISCARD;
        end
      end
      default: begin
        w_flush      = 1'b1;
        w_req_addr_n = r_pc;
        w_state_n    = ST_FETCH;
      end
    endcase
  end

  // PC, request address, state and hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_req_addr <= w_req_addr_n;
      if (w_hold_capture) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc4   <= w_pc_plus4;
      end else begin
        r_hold_instr <= r_hold_instr;
        r_hold_pc4   <= r_hold_pc4;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (w_load_instr),
    .i_pc_plus4 (w_load_pc4),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  assign imem_req  = !reset && (r_state != ST_HOLD);
  assign imem_addr = r_req_addr;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory returns the request address as data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] pc_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .pc_out          (pc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0000_0000;
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_pc",    pc_out,               32'h0040_0000);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr,          32'h0000_0000);
    chk("rst_pc4",   if_id_pc_plus4,       32'h0000_0000);

    // Zero-wait memory: one instruction per cycle.
    reset = 1'b0; imem_ready = 1'b1; #1;
    chk("zw_req",  {31'd0, imem_req}, 32'd1);
    chk("zw_addr0", imem_addr,        32'h0040_0000);
    tick();
    chk("zw_i0",  if_id_instr,          32'h0040_0000);
    chk("zw_p0",  if_id_pc_plus4,       32'h0040_0004);
    chk("zw_v0",  {31'd0, if_id_valid}, 32'd1);
    tick();
    chk("zw_i1",  if_id_instr,    32'h0040_0004);
    chk("zw_p1",  if_id_pc_plus4, 32'h0040_0008);
    tick();
    chk("zw_i2",  if_id_instr,    32'h0040_0008);
    chk("zw_p2",  if_id_pc_plus4, 32'h0040_000C);

    // 3-cycle latency at 0x0040_000C: two bubbles, address stable.
    imem_ready = 1'b0;
    tick();
    chk("lat_v1",  {31'd0, if_id_valid}, 32'd0);
    chk("lat_a1",  imem_addr,            32'h0040_000C);
    tick();
    chk("lat_v2",  {31'd0, if_id_valid}, 32'd0);
    chk("lat_a2",  imem_addr,            32'h0040_000C);
    chk("lat_r2",  {31'd0, imem_req},    32'd1);
    imem_ready = 1'b1;
    tick();
    chk("lat_i",   if_id_instr,          32'h0040_000C);
    chk("lat_v3",  {31'd0, if_id_valid}, 32'd1);
    chk("lat_a3",  imem_addr,            32'h0040_0010);

    // Stall for 4 cycles while the word at 0x0040_0010 arrives.
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stl_i",   if_id_instr,       32'h0040_000C);
      chk("stl_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stl_rel_i", if_id_instr,          32'h0040_0010);
    chk("stl_rel_p", if_id_pc_plus4,       32'h0040_0014);
    chk("stl_rel_v", {31'd0, if_id_valid}, 32'd1);
    chk("stl_rel_a", imem_addr,            32'h0040_0014);
    tick();
    chk("stl_nxt_i", if_id_instr, 32'h0040_0014);

    // Redirect to 0x0040_0103 while the request at 0x0040_0018 is outstanding.
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0103;
    tick();
    chk("rd_v",    {31'd0, if_id_valid}, 32'd0);
    chk("rd_pc",   pc_out,               32'h0040_0100);
    chk("rd_addr", imem_addr,            32'h0040_0018);
    chk("rd_req",  {31'd0, imem_req},    32'd1);
    redirect_valid = 1'b0; imem_ready = 1'b1;
    tick();
    chk("rd_drop_v", {31'd0, if_id_valid}, 32'd0);
    chk("rd_drop_i", if_id_instr,          32'h0000_0000);
    chk("rd_naddr",  imem_addr,            32'h0040_0100);
    tick();
    chk("rd_tgt_i", if_id_instr,          32'h0040_0100);
    chk("rd_tgt_v", {31'd0, if_id_valid}, 32'd1);

    // Redirect together with stall while holding a buffered word.
    stall = 1'b1;
    tick();
    chk("hr_hold_i", if_id_instr,       32'h0040_0100);
    chk("hr_hold_r", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h0040_0200;
    tick();
    chk("hr_v",    {31'd0, if_id_valid}, 32'd0);
    chk("hr_i",    if_id_instr,          32'h0000_0000);
    chk("hr_pc",   pc_out,               32'h0040_0200);
    chk("hr_addr", imem_addr,            32'h0040_0200);
    chk("hr_req",  {31'd0, imem_req},    32'd1);
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    chk("hr_tgt_i", if_id_instr,          32'h0040_0200);
    chk("hr_tgt_v", {31'd0, if_id_valid}, 32'd1);

    // Redirect to the top of memory with ready=1: PC wraps modulo 2^32.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("wr_addr", imem_addr,            32'hFFFF_FFFC);
    chk("wr_v",    {31'd0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("wr_i",    if_id_instr,    32'hFFFF_FFFC);
    chk("wr_p4",   if_id_pc_plus4, 32'h0000_0000);
    chk("wr_next", imem_addr,      32'h0000_0000);

    // Reset mid-request, with a response arriving during reset.
    imem_ready = 1'b0;
    tick();
    reset = 1'b1; imem_ready = 1'b1; #1;
    chk("mr_req0", {31'd0, imem_req}, 32'd0);
    tick();
    chk("mr_pc",   pc_out,               32'h0040_0000);
    chk("mr_v",    {31'd0, if_id_valid}, 32'd0);
    chk("mr_i",    if_id_instr,          32'h0000_0000);
    reset = 1'b0; imem_ready = 1'b0;
    tick();
    chk("mr_addr", imem_addr,            32'h0040_0000);
    chk("mr_req1", {31'd0, imem_req},    32'd1);
    chk("mr_v2",   {31'd0, if_id_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
